pong_pixel_renderer: RTL



---
 rtl/pong_pixel_renderer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pong_pixel_renderer.sv
`default_nettype none
// pong_pixel_renderer: per-frame snapshot of paddle/ball positions and a 3-stage
// pixel colour pipeline with matching de/hsync/vsync delay for direct VGA drive.
module pong_pixel_renderer #(
   parameter int X_POS_W   = 10,
   parameter int Y_POS_W   = 10,
   parameter int H_RES     = 640,
   parameter int V_RES     = 480,
   parameter int PADDLE_W  = 8,
   parameter int PADDLE_H  = 64,
   parameter int BALL_SIDE = 8,
   parameter int BORDER    = 8,
   parameter int RGB_W     = 12
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               new_frame_i,
   input  logic [X_POS_W-1:0] player_paddle_x_i,
   input  logic [Y_POS_W-1:0] player_paddle_y_i,
   input  logic [X_POS_W-1:0] pc_paddle_x_i,
   input  logic [Y_POS_W-1:0] pc_paddle_y_i,
   input  logic [X_POS_W-1:0] ball_x_i,
   input  logic [Y_POS_W-1:0] ball_y_i,
   input  logic [X_POS_W-1:0] pixel_x_i,
   input  logic [Y_POS_W-1:0] pixel_y_i,
   input  logic               de_i,
   input  logic               hsync_i,
   input  logic               vsync_i,
   output logic [RGB_W-1:0]   rgb_o,
   output logic               de_o,
   output logic               hsync_o,
   output logic               vsync_o
);

   localparam logic [X_POS_W:0]   PADDLE_W_X  = (X_POS_W+1)'(PADDLE_W);
   localparam logic [Y_POS_W:0]   PADDLE_H_Y  = (Y_POS_W+1)'(PADDLE_H);
   localparam logic [X_POS_W:0]   BALL_W_X    = (X_POS_W+1)'(BALL_SIDE);
   localparam logic [Y_POS_W:0]   BALL_H_Y    = (Y_POS_W+1)'(BALL_SIDE);
   localparam logic [Y_POS_W-1:0] BORDER_TOP  = Y_POS_W'(BORDER);
   localparam logic [Y_POS_W-1:0] BORDER_BOT  = Y_POS_W'(V_RES - BORDER);
   localparam logic [X_POS_W-1:0] NET_LEFT    = X_POS_W'(H_RES/2 - 1);
   localparam logic [X_POS_W-1:0] NET_RIGHT   = X_POS_W'(H_RES/2);
   localparam logic [RGB_W-1:0]   COL_WHITE   = RGB_W'(12'hFFF);
   localparam logic [RGB_W-1:0]   COL_PLAYER  = RGB_W'(12'h0F0);
   localparam logic [RGB_W-1:0]   COL_PC      = RGB_W'(12'hF00);
   localparam logic [RGB_W-1:0]   COL_NET     = RGB_W'(12'h888);

   // Spans are evaluated one bit wider so an object at the far edge never wraps to 0.
   function automatic logic in_span_x(input logic [X_POS_W-1:0] p,
                                      input logic [X_POS_W-1:0] left,
                                      input logic [X_POS_W:0]   len);
      return ({1'b0, p} >= {1'b0, left}) && ({1'b0, p} < ({1'b0, left} + len));
   endfunction

   function automatic logic in_span_y(input logic [Y_POS_W-1:0] p,
                                      input logic [Y_POS_W-1:0] top,
                                      input logic [Y_POS_W:0]   len);
      return ({1'b0, p} >= {1'b0, top}) && ({1'b0, p} < ({1'b0, top} + len));
   endfunction

   logic [X_POS_W-1:0] snap_player_x, snap_pc_x, snap_ball_x;
   logic [Y_POS_W-1:0] snap_player_y, snap_pc_y, snap_ball_y;
   logic               snap_valid;

   logic [X_POS_W-1:0] px1;
   logic [Y_POS_W-1:0] py1;
   logic               de1, hs1, vs1;

   logic               ball2, player2, pc2, border2, net2;
   logic               de2, hs2, vs2;

   logic               ball_hit, player_hit, pc_hit, border_hit, net_hit;
   logic [RGB_W-1:0]   colour;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         snap_player_x <= '0;
         snap_player_y <= '0;
         snap_pc_x     <= '0;
         snap_pc_y     <= '0;
         snap_ball_x   <= '0;
         snap_ball_y   <= '0;
         snap_valid    <= 1'b0;
      end else if (new_frame_i) begin
         snap_player_x <= player_paddle_x_i;
         snap_player_y <= player_paddle_y_i;
         snap_pc_x     <= pc_paddle_x_i;
         snap_pc_y     <= pc_paddle_y_i;
         snap_ball_x   <= ball_x_i;
         snap_ball_y   <= ball_y_i;
         snap_valid    <= 1'b1;
      end
   end

   always_comb begin
      ball_hit   = snap_valid && in_span_x(px1, snap_ball_x, BALL_W_X)
                              && in_span_y(py1, snap_ball_y, BALL_H_Y);
      player_hit = snap_valid && in_span_x(px1, snap_player_x, PADDLE_W_X)
                              && in_span_y(py1, snap_player_y, PADDLE_H_Y);
      pc_hit     = snap_valid && in_span_x(px1, snap_pc_x, PADDLE_W_X)
                              && in_span_y(py1, snap_pc_y, PADDLE_H_Y);
      border_hit = (py1 < BORDER_TOP) || (py1 >= BORDER_BOT);
      net_hit    = ((px1 == NET_LEFT) || (px1 == NET_RIGHT)) && (py1[3] == 1'b0);
   end

   always_comb begin
      colour = '0;
      if (de2) begin
         if (ball2)        colour = COL_WHITE;
         else if (player2) colour = COL_PLAYER;
         else if (pc2)     colour = COL_PC;
         else if (border2) colour = COL_WHITE;
         else if (net2)    colour = COL_NET;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         px1     <= '0;
         py1     <= '0;
         de1     <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
         ball2   <= 1'b0;
         player2 <= 1'b0;
         pc2     <= 1'b0;
         border2 <= 1'b0;
         net2    <= 1'b0;
         de2     <= 1'b0;
         hs2     <= 1'b1;
         vs2     <= 1'b1;
         rgb_o   <= '0;
         de_o    <= 1'b0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         px1     <= pixel_x_i;
         py1     <= pixel_y_i;
         de1     <= de_i;
         hs1     <= hsync_i;
         vs1     <= vsync_i;
         ball2   <= ball_hit;
         player2 <= player_hit;
         pc2     <= pc_hit;
         border2 <= border_hit;
         net2    <= net_hit;
         de2     <= de1;
         hs2     <= hs1;
         vs2     <= vs1;
         rgb_o   <= colour;
         de_o    <= de2;
         hsync_o <= hs2;
         vsync_o <= vs2;
      end
   end

endmodule
`default_nettype wire
